memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store sequencer between the pipeline and the core memory bus.
//
// A request is sampled in IDLE when start is high and exactly one of isLoad/isStore is set.
// Aligned requests are registered and presented on the bus in ACCESS until busAck; the
// completion is reported with a one-cycle dataValid pulse from DONE. Misaligned requests
// never reach the bus and give a one-cycle addressMisaligned pulse instead.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, isLoad, isStore   request strobe and access type
//   funct3                   RV32 width code (stores use funct3[1:0])
//   address, storeData       effective byte address, rs2 value
//   busAddress..busWriteEnable  initiator side of the memory bus
//   busDataRead, busAck      responder data and completion
//   loadData                 raw aligned word from the last completed load
//   dataValid, stall         completion pulse, pipeline hold
//   addressMisaligned        one-cycle pulse for a rejected misaligned request
//   busError                 one-cycle pulse on bus timeout (0 when timeout is disabled)
//
// Build option
//   MEMORY_TIMEOUT_EN        adds an 8-bit ACCESS watchdog and the ERROR state

module memory_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [31:0] busAddress,
  output logic [3:0]  busByteSelect,
  output logic [31:0] busDataWrite,
  output logic        busReadEnable,
  output logic        busWriteEnable,
  input  logic [31:0] busDataRead,
  input  logic        busAck,
  output logic [31:0] loadData,
  output logic        dataValid,
  output logic        stall,
  output logic        addressMisaligned,
  output logic        busError
);

`ifdef MEMORY_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
`endif

  state_e      stateQ, stateD;
  logic [29:0] wordAddrQ;
  logic [3:0]  byteSelQ;
  logic [31:0] writeDataQ;
  logic        isLoadQ;
  logic [31:0] loadDataQ;
  logic        misalignedQ;
`ifdef MEMORY_TIMEOUT_EN
  logic [7:0]  timeoutQ;
`endif

  // Request decode
  logic [3:0]  baseMask;
  logic [6:0]  shiftedMask;
  logic [31:0] storeWord;
  logic        misaligned;
  logic        validReq;
  logic        accept;

  always_comb begin
    baseMask = 4'b0000;
    case (funct3[1:0])
      2'b10:   baseMask = 4'b1111;
      2'b01:   baseMask = 4'b0011;
      2'b00:   baseMask = 4'b0001;
      default: baseMask = 4'b0000;
    endcase
    shiftedMask = {3'b000, baseMask} << address[1:0];
    // Lanes spilling past byte 3 cross a word boundary; a zero mask is an illegal width.
    misaligned  = (shiftedMask[6:4] != 3'b000) || (baseMask == 4'b0000);
    validReq    = (stateQ == StIdle) && start && (isLoad ^ isStore);
    accept      = validReq && !misaligned;

    storeWord = storeData;
    case (funct3[1:0])
      2'b00:   storeWord = {4{storeData[7:0]}};
      2'b01:   storeWord = {2{storeData[15:0]}};
      default: storeWord = storeData;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= StIdle;
      wordAddrQ   <= '0;
      byteSelQ    <= '0;
      writeDataQ  <= '0;
      isLoadQ     <= 1'b0;
      loadDataQ   <= '0;
      misalignedQ <= 1'b0;
`ifdef MEMORY_TIMEOUT_EN
      timeoutQ    <= '0;
`endif
    end else begin
      stateQ      <= stateD;
      misalignedQ <= validReq && misaligned;
      if (accept) begin
        wordAddrQ  <= address[31:2];
        byteSelQ   <= shiftedMask[3:0];
        writeDataQ <= storeWord;
        isLoadQ    <= isLoad;
      end
      if ((stateQ == StAccess) && busAck && isLoadQ) begin
        loadDataQ <= busDataRead;
      end
`ifdef MEMORY_TIMEOUT_EN
      if (accept) begin
        timeoutQ <= '0;
      end else if ((stateQ == StAccess) && !busAck) begin
        timeoutQ <= timeoutQ + 8'd1;
      end
`endif
    end
  end

  // Next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (accept) stateD = StAccess;
      end
      StAccess: begin
        if (busAck) begin
          stateD = StDone;
`ifdef MEMORY_TIMEOUT_EN
        // Counter reaches 255 on this edge: 255 ACCESS cycles without an ack.
        end else if (timeoutQ == 8'd254) begin
          stateD = StError;
`endif
        end
      end
      StDone:  stateD = StIdle;
`ifdef MEMORY_TIMEOUT_EN
      StError: stateD = StIdle;
`endif
      default: stateD = StIdle;
    endcase
  end

  // Outputs; bus signals are gated by state so they drop with an asynchronous reset.
  always_comb begin
    busAddress        = '0;
    busByteSelect     = '0;
    busDataWrite      = '0;
    busReadEnable     = 1'b0;
    busWriteEnable    = 1'b0;
    dataValid         = 1'b0;
    busError          = 1'b0;
    loadData          = loadDataQ;
    addressMisaligned = misalignedQ;
    stall             = !rst && (accept || (stateQ == StAccess));
    unique case (stateQ)
      StAccess: begin
        busAddress     = {wordAddrQ, 2'b00};
        busByteSelect  = byteSelQ;
        busDataWrite   = isLoadQ ? 32'h0 : writeDataQ;
        busReadEnable  = isLoadQ;
        busWriteEnable = !isLoadQ;
      end
      StDone:  dataValid = 1'b1;
`ifdef MEMORY_TIMEOUT_EN
      StError: busError = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, isLoad, isStore;
  logic [2:0]  funct3;
  logic [31:0] address, storeData;
  logic [31:0] busAddress, busDataWrite, busDataRead, loadData;
  logic [3:0]  busByteSelect;
  logic        busReadEnable, busWriteEnable, busAck;
  logic        dataValid, stall, addressMisaligned, busError;

  memory_access_unit dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .isLoad            (isLoad),
    .isStore           (isStore),
    .funct3            (funct3),
    .address           (address),
    .storeData         (storeData),
    .busAddress        (busAddress),
    .busByteSelect     (busByteSelect),
    .busDataWrite      (busDataWrite),
    .busReadEnable     (busReadEnable),
    .busWriteEnable    (busWriteEnable),
    .busDataRead       (busDataRead),
    .busAck            (busAck),
    .loadData          (loadData),
    .dataValid         (dataValid),
    .stall             (stall),
    .addressMisaligned (addressMisaligned),
    .busError          (busError)
  );

  always #5 clk = ~clk;

  // Expected completion events: kind = {busError, addressMisaligned, dataValid}
  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  int          vecCount  = 0;
  int          missCount = 0;
  logic [31:0] expLoad   = 32'h0;
  logic [2:0]  monKind;
  exp_t        monExp;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      monKind = {busError, addressMisaligned, dataValid};
      if (monKind != 3'b000) begin
        if (expQ.size() == 0) begin
          checkVal("unexpectedEvent", 32'(monKind), 32'h0);
        end else begin
          monExp = expQ.pop_front();
          checkVal("eventKind", 32'(monKind), 32'(monExp.kind));
          if (dataValid) checkVal("loadData", loadData, monExp.data);
        end
      end
    end
  end

  task automatic doAccess(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input int ackDelay, input logic [31:0] rd);
    logic [3:0]  m;
    logic [6:0]  sh;
    logic        mis;
    logic [31:0] wd;
    exp_t        e;
    case (f3[1:0])
      2'b10:   m = 4'hF;
      2'b01:   m = 4'h3;
      2'b00:   m = 4'h1;
      default: m = 4'h0;
    endcase
    sh  = {3'b000, m} << addr[1:0];
    mis = (sh[6:4] != 3'b000) || (m == 4'h0);
    case (f3[1:0])
      2'b00:   wd = {4{sd[7:0]}};
      2'b01:   wd = {2{sd[15:0]}};
      default: wd = sd;
    endcase

    @(negedge clk);
    start = 1'b1; isLoad = ld; isStore = !ld; funct3 = f3; address = addr; storeData = sd;
    if (mis) begin
      e = '{kind: 3'b010, data: 32'h0};
    end else begin
      if (ld) expLoad = rd;
      e = '{kind: 3'b001, data: expLoad};
    end
    expQ.push_back(e);
    #1 checkVal("stallAccept", 32'(stall), 32'(!mis));

    if (mis) begin
      @(negedge clk);
      start = 1'b0;
      checkVal("misEnables", 32'({busReadEnable, busWriteEnable, stall}), 32'h0);
      @(negedge clk);
      checkVal("misBusIdle", 32'(busByteSelect), 32'h0);
    end else begin
      for (int i = 0; i <= ackDelay; i++) begin
        @(negedge clk);
        checkVal("busAddress", busAddress, {addr[31:2], 2'b00});
        checkVal("byteSelect", 32'(busByteSelect), 32'(sh[3:0]));
        checkVal("enables", 32'({busReadEnable, busWriteEnable}), 32'({ld, !ld}));
        checkVal("stallAccess", 32'(stall), 32'h1);
        if (!ld) checkVal("writeData", busDataWrite, wd);
        if (i == ackDelay) begin
          start = 1'b0; busAck = 1'b1; busDataRead = rd;
        end else begin
          // Requests while busy must be ignored and registered fields must not move.
          start = 1'b1; address = $urandom; storeData = $urandom;
        end
      end
      @(negedge clk);
      busAck = 1'b0; busDataRead = $urandom;
      checkVal("doneEnables", 32'({busReadEnable, busWriteEnable, stall}), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  bit rl;
  logic [2:0] rf;

  initial begin
    rst = 1'b1; start = 1'b0; isLoad = 1'b0; isStore = 1'b0; funct3 = 3'b0;
    address = 32'h0; storeData = 32'h0; busDataRead = 32'h0; busAck = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rstBusAddress", busAddress, 32'h0);
    checkVal("rstByteSelect", 32'(busByteSelect), 32'h0);
    checkVal("rstWriteData", busDataWrite, 32'h0);
    checkVal("rstLoadData", loadData, 32'h0);
    checkVal("rstFlags", 32'({busReadEnable, busWriteEnable, dataValid, stall,
                              addressMisaligned, busError}), 32'h0);
    rst = 1'b0;

    doAccess(1'b1, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);   // LW
    doAccess(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0);   // SB lane 3
    doAccess(1'b1, 3'b001, 32'h0000_0103, 32'h0, 0, 32'h0);           // LH misaligned
    doAccess(1'b1, 3'b010, 32'h0000_0200, 32'h0, 5, 32'h1357_9BDF);   // LW slow ack
    doAccess(1'b0, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 32'h0);   // SH upper half
    doAccess(1'b1, 3'b100, 32'h0000_0201, 32'h0, 0, 32'h00AB_0000);   // LBU lane 1
    doAccess(1'b1, 3'b101, 32'h0000_0002, 32'h0, 0, 32'hCAFE_0000);   // LHU upper half
    doAccess(1'b1, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0);           // LW misaligned
    doAccess(1'b1, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);           // illegal width

    // Both type bits high is not a request.
    @(negedge clk);
    start = 1'b1; isLoad = 1'b1; isStore = 1'b1; funct3 = 3'b010; address = 32'h100;
    #1 checkVal("invalidStall", 32'(stall), 32'h0);
    @(negedge clk);
    start = 1'b0;
    checkVal("invalidBus", 32'({busReadEnable, busWriteEnable}), 32'h0);

    // Reset while a load waits for its ack.
    @(negedge clk);
    start = 1'b1; isLoad = 1'b1; isStore = 1'b0; funct3 = 3'b010; address = 32'h300;
    @(negedge clk);
    start = 1'b0;
    checkVal("preRstRead", 32'(busReadEnable), 32'h1);
    #2 rst = 1'b1;
    #1 checkVal("rstAsyncEnables", 32'({busReadEnable, busWriteEnable, stall}), 32'h0);
    checkVal("rstAsyncAddr", busAddress, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expLoad = 32'h0;
    checkVal("rstClearsLoad", loadData, 32'h0);
    busAck = 1'b1; busDataRead = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    busAck = 1'b0;
    doAccess(1'b1, 3'b010, 32'h0000_0100, 32'h0, 1, 32'h0BAD_F00D);

    // Never-acked load.
    @(negedge clk);
    start = 1'b1; isLoad = 1'b1; isStore = 1'b0; funct3 = 3'b010; address = 32'h40;
    n = 0;
`ifdef MEMORY_TIMEOUT_EN
    expQ.push_back('{kind: 3'b100, data: 32'h0});
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busError) break;
      if (busReadEnable) n++;
    end
    checkVal("timeoutCycles", 32'(n), 32'd255);
    @(negedge clk);
    checkVal("afterError", 32'({busReadEnable, busError, stall}), 32'h0);
`else
    expLoad = 32'h2468_ACE0;
    expQ.push_back('{kind: 3'b001, data: expLoad});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall && busReadEnable) n++;
    end
    checkVal("stallHeld", 32'(n), 32'd300);
    busAck = 1'b1; busDataRead = 32'h2468_ACE0;
    @(negedge clk);
    busAck = 1'b0;
    checkVal("lateAckDone", 32'(busError), 32'h0);
`endif

    // Random mix of widths, offsets and ack delays.
    for (int k = 0; k < 16; k++) begin
      rl = 1'($urandom_range(0, 1));
      if (rl) begin
        case ($urandom_range(0, 4))
          0:       rf = 3'b000;
          1:       rf = 3'b001;
          2:       rf = 3'b010;
          3:       rf = 3'b100;
          default: rf = 3'b101;
        endcase
      end else begin
        rf = 3'($urandom_range(0, 2));
      end
      doAccess(rl, rf, $urandom, $urandom, $urandom_range(0, 3), $urandom);
    end

    repeat (2) @(negedge clk);
    checkVal("queueDrained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
